// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter between instruction fetch and the load/store buffer,
// presenting a single held-stable request to the memory controller.
module memory_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_type,
    input  logic [31:0] ls_data,
    output logic        ls_ready,
    output logic [31:0] ls_result,
    output logic        mc_valid,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_type,
    output logic [31:0] mc_data,
    input  logic        mc_ready,
    input  logic [31:0] mc_result
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_LS,
        DRAIN,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        lastLs_q, lastLs_d;
    logic        ifReady_q, ifReady_d;
    logic [31:0] ifData_q, ifData_d;
    logic        lsReady_q, lsReady_d;
    logic [31:0] lsResult_q, lsResult_d;
    logic        mcValid_q, mcValid_d;
    logic        mcWr_q, mcWr_d;
    logic [31:0] mcAddr_q, mcAddr_d;
    logic [2:0]  mcType_q, mcType_d;
    logic [31:0] mcData_q, mcData_d;

    logic ifEligible;
    logic grantIf;
    logic grantLs;

    // A flushed fetch is never eligible; on a tie the side that did not win last time goes first.
    assign ifEligible = if_valid && !clear;
    assign grantIf    = ifEligible && (!ls_valid || lastLs_q);
    assign grantLs    = ls_valid && !grantIf;

    always_comb begin
        state_d    = state_q;
        lastLs_d   = lastLs_q;
        ifReady_d  = ifReady_q;
        ifData_d   = ifData_q;
        lsReady_d  = lsReady_q;
        lsResult_d = lsResult_q;
        mcValid_d  = mcValid_q;
        mcWr_d     = mcWr_q;
        mcAddr_d   = mcAddr_q;
        mcType_d   = mcType_q;
        mcData_d   = mcData_q;

        case (state_q)
            IDLE: begin
                if (grantIf) begin
                    lastLs_d  = 1'b0;
                    mcValid_d = 1'b1;
                    mcWr_d    = 1'b0;
                    mcAddr_d  = if_addr;
                    mcType_d  = 3'b010;
                    mcData_d  = 32'h0;
                    state_d   = BUSY_IF;
                end else if (grantLs) begin
                    lastLs_d  = 1'b1;
                    mcValid_d = 1'b1;
                    mcWr_d    = ls_wr;
                    mcAddr_d  = ls_addr;
                    mcType_d  = ls_type;
                    mcData_d  = ls_data;
                    state_d   = BUSY_LS;
                end
            end

            // A flush during a fetch must not abort the controller, so it waits out the transfer in DRAIN.
            BUSY_IF: begin
                if (mc_ready) begin
                    mcValid_d = 1'b0;
                    if (clear) begin
                        state_d = IDLE;
                    end else begin
                        ifData_d  = mc_result;
                        ifReady_d = 1'b1;
                        state_d   = RESP;
                    end
                end else if (clear) begin
                    state_d = DRAIN;
                end
            end

            BUSY_LS: begin
                if (mc_ready) begin
                    mcValid_d  = 1'b0;
                    lsResult_d = mc_result;
                    lsReady_d  = 1'b1;
                    state_d    = RESP;
                end
            end

            DRAIN: begin
                if (mc_ready) begin
                    mcValid_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            RESP: begin
                ifReady_d = 1'b0;
                lsReady_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            lastLs_q   <= 1'b1;
            ifReady_q  <= 1'b0;
            ifData_q   <= 32'h0;
            lsReady_q  <= 1'b0;
            lsResult_q <= 32'h0;
            mcValid_q  <= 1'b0;
            mcWr_q     <= 1'b0;
            mcAddr_q   <= 32'h0;
            mcType_q   <= 3'b000;
            mcData_q   <= 32'h0;
        end else if (rdy) begin
            state_q    <= state_d;
            lastLs_q   <= lastLs_d;
            ifReady_q  <= ifReady_d;
            ifData_q   <= ifData_d;
            lsReady_q  <= lsReady_d;
            lsResult_q <= lsResult_d;
            mcValid_q  <= mcValid_d;
            mcWr_q     <= mcWr_d;
            mcAddr_q   <= mcAddr_d;
            mcType_q   <= mcType_d;
            mcData_q   <= mcData_d;
        end
    end

    assign if_ready  = ifReady_q;
    assign if_data   = ifData_q;
    assign ls_ready  = lsReady_q;
    assign ls_result = lsResult_q;
    assign mc_valid  = mcValid_q;
    assign mc_wr     = mcWr_q;
    assign mc_addr   = mcAddr_q;
    assign mc_type   = mcType_q;
    assign mc_data   = mcData_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: behavioural memory controller, response scoreboards,
// a table of single transactions and hand-written multi-cycle corner sequences.
module tb_memory_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ls_valid;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [2:0]  ls_type;
    logic [31:0] ls_data;
    logic        ls_ready;
    logic [31:0] ls_result;
    logic        mc_valid;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_type;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [31:0] mc_result;

    memory_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_type(ls_type),
        .ls_data(ls_data), .ls_ready(ls_ready), .ls_result(ls_result),
        .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_type(mc_type),
        .mc_data(mc_data), .mc_ready(mc_ready), .mc_result(mc_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] ifQ[$];
    logic [31:0] lsQ[$];
    bit          grantLog[$];

    task automatic checkOutput(input string name, input logic [134:0] act, input logic [134:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: little-endian byte memory, byte/half done in one cycle, word in three.
    logic [7:0]  mem [1024];
    logic        mcBusy;
    int          mcCnt;
    logic [31:0] mcPending;

    function automatic logic [7:0] initByte(input logic [9:0] a);
        case (a)
            10'h100: return 8'h13;  10'h101: return 8'h05;
            10'h104: return 8'h93;  10'h106: return 8'h10;
            10'h108: return 8'h33;  10'h109: return 8'h81;  10'h10A: return 8'h20;
            10'h10C: return 8'hDE;  10'h10D: return 8'hC0;  10'h10E: return 8'hAD;  10'h10F: return 8'hDE;
            10'h040: return 8'h80;  10'h041: return 8'h7F;
            10'h044: return 8'h34;  10'h045: return 8'h12;  10'h046: return 8'hFE;  10'h047: return 8'hCA;
            10'h048: return 8'h11;  10'h049: return 8'h22;  10'h04A: return 8'h33;  10'h04B: return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] readMem(input logic [31:0] addr, input logic [2:0] typ);
        logic [9:0] a;
        logic [7:0] b0, b1, b2, b3;
        a  = addr[9:0];
        b0 = mem[a];
        b1 = mem[a + 10'd1];
        b2 = mem[a + 10'd2];
        b3 = mem[a + 10'd3];
        case (typ)
            3'b000:  return {24'h0, b0};
            3'b001:  return {16'h0, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {{24{b0[7]}}, b0};
            3'b101:  return {{16{b1[7]}}, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int latOf(input logic [2:0] typ);
        return (typ[1:0] == 2'b10) ? 3 : 1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mcBusy    <= 1'b0;
            mcCnt     <= 0;
            mcPending <= 32'h0;
            mc_ready  <= 1'b0;
            mc_result <= 32'hDEAD_BEEF;
            for (int i = 0; i < 1024; i++) mem[i] <= initByte(10'(i));
        end else if (rdy) begin
            mc_ready  <= 1'b0;
            mc_result <= 32'hDEAD_BEEF;
            if (mcBusy) begin
                if (mcCnt == 1) begin
                    mc_ready  <= 1'b1;
                    mc_result <= mcPending;
                    mcBusy    <= 1'b0;
                end else begin
                    mcCnt <= mcCnt - 1;
                end
            end else if (mc_valid && !mc_ready) begin
                if (mc_wr) begin
                    mem[mc_addr[9:0]] <= mc_data[7:0];
                    if (mc_type[1:0] != 2'b00) mem[mc_addr[9:0] + 10'd1] <= mc_data[15:8];
                    if (mc_type[1:0] == 2'b10) begin
                        mem[mc_addr[9:0] + 10'd2] <= mc_data[23:16];
                        mem[mc_addr[9:0] + 10'd3] <= mc_data[31:24];
                    end
                end
                if (latOf(mc_type) == 1) begin
                    mc_ready  <= 1'b1;
                    mc_result <= mc_wr ? 32'h0 : readMem(mc_addr, mc_type);
                end else begin
                    mcBusy    <= 1'b1;
                    mcCnt     <= latOf(mc_type) - 1;
                    mcPending <= mc_wr ? 32'h0 : readMem(mc_addr, mc_type);
                end
            end
        end
    end

    // Protocol monitor and scoreboard pop, using rst/rdy as the DUT saw them on the last edge.
    logic         edgeRst, edgeRdy;
    logic [134:0] allOut, prevOut;
    logic [67:0]  mcFields, prevMc;
    logic         prevIfReady, prevLsReady, prevMcValid, prevMcReady;

    assign allOut   = {if_ready, if_data, ls_ready, ls_result, mc_valid, mc_wr, mc_addr, mc_type, mc_data};
    assign mcFields = {mc_wr, mc_addr, mc_type, mc_data};

    always @(posedge clk) begin
        edgeRst <= rst;
        edgeRdy <= rdy;
    end

    always @(negedge clk) begin
        if (edgeRst === 1'b0) begin
            checkOutput("resetOutputs", allOut, 135'(0));
        end else if (edgeRdy === 1'b0) begin
            checkOutput("freezeOutputs", allOut, prevOut);
        end else begin
            if (prevMcReady) checkOutput("mcValidAfterReady", 135'(mc_valid), 135'(0));
            if (prevMcValid && mc_valid) checkOutput("mcStable", 135'(mcFields), 135'(prevMc));
            if (prevMcValid && !mc_valid) checkOutput("mcDropOnlyOnReady", 135'(prevMcReady), 135'(1));
            if (!prevMcValid && mc_valid) grantLog.push_back(mc_addr[9:8] == 2'b01);
            if (prevIfReady) checkOutput("ifPulseWidth", 135'(if_ready), 135'(0));
            if (prevLsReady) checkOutput("lsPulseWidth", 135'(ls_ready), 135'(0));
            if (if_ready && !prevIfReady) begin
                if (ifQ.size() == 0) checkOutput("ifUnexpectedReady", 135'(ifQ.size()), 135'(1));
                else checkOutput("ifData", 135'(if_data), 135'(ifQ.pop_front()));
            end
            if (ls_ready && !prevLsReady) begin
                if (lsQ.size() == 0) checkOutput("lsUnexpectedReady", 135'(lsQ.size()), 135'(1));
                else checkOutput("lsResult", 135'(ls_result), 135'(lsQ.pop_front()));
            end
        end
        prevOut     <= allOut;
        prevMc      <= mcFields;
        prevIfReady <= if_ready;
        prevLsReady <= ls_ready;
        prevMcValid <= mc_valid;
        prevMcReady <= mc_ready;
    end

    typedef struct packed {
        logic        isLs;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] data;
        logic [31:0] expResult;
        logic [3:0]  expCycles;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mkVec(input logic isLs, input logic wr, input logic [31:0] addr,
                                   input logic [2:0] typ, input logic [31:0] data,
                                   input logic [31:0] expResult, input logic [3:0] expCycles);
        vec_t v;
        v.isLs = isLs; v.wr = wr; v.addr = addr; v.typ = typ;
        v.data = data; v.expResult = expResult; v.expCycles = expCycles;
        return v;
    endfunction

    task automatic waitReady(input bit isLs, input string name, output int cycles);
        cycles = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((isLs ? ls_ready : if_ready) === 1'b1) begin
                cycles = i;
                return;
            end
        end
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: no ready pulse within 60 cycles, required one", name);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string nm;
        int    cyc;
        nm = $sformatf("vec%0d", idx);
        if (v.isLs) begin
            ls_wr    = v.wr;
            ls_addr  = v.addr;
            ls_type  = v.typ;
            ls_data  = v.data;
            ls_valid = 1'b1;
            lsQ.push_back(v.expResult);
        end else begin
            if_addr  = v.addr;
            if_valid = 1'b1;
            ifQ.push_back(v.expResult);
        end
        waitReady(v.isLs, nm, cyc);
        if_valid = 1'b0;
        ls_valid = 1'b0;
        checkOutput({nm, "Latency"}, 135'(cyc), 135'(v.expCycles));
        @(negedge clk);
    endtask

    function automatic logic [31:0] fetchExp(input int i);
        case (i)
            0:       return 32'h0000_0513;
            1:       return 32'h0010_0093;
            default: return 32'h0020_8133;
        endcase
    endfunction

    task automatic runFetches(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            if_addr  = 32'h100 + 32'(4 * i);
            if_valid = 1'b1;
            ifQ.push_back(fetchExp(i));
            waitReady(1'b0, "altFetch", cyc);
        end
        if_valid = 1'b0;
    endtask

    task automatic runLoads(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            ls_wr    = 1'b0;
            ls_type  = 3'b000;
            ls_data  = 32'h0;
            ls_addr  = 32'h48 + 32'(i);
            ls_valid = 1'b1;
            lsQ.push_back(32'h11 * 32'(i + 1));
            waitReady(1'b1, "altLoad", cyc);
        end
        ls_valid = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        grantLog.delete();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc;
        int  pulses;
        bit  g;

        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        if_valid = 1'b0; if_addr = 32'h0;
        ls_valid = 1'b0; ls_wr = 1'b0; ls_addr = 32'h0; ls_type = 3'b000; ls_data = 32'h0;

        vecs[0]  = mkVec(1'b0, 1'b0, 32'h100, 3'b010, 32'h0,         32'h0000_0513, 4'd5);
        vecs[1]  = mkVec(1'b0, 1'b0, 32'h104, 3'b010, 32'h0,         32'h0010_0093, 4'd5);
        vecs[2]  = mkVec(1'b1, 1'b0, 32'h040, 3'b100, 32'h0,         32'hFFFF_FF80, 4'd3);
        vecs[3]  = mkVec(1'b1, 1'b0, 32'h040, 3'b000, 32'h0,         32'h0000_0080, 4'd3);
        vecs[4]  = mkVec(1'b1, 1'b0, 32'h041, 3'b100, 32'h0,         32'h0000_007F, 4'd3);
        vecs[5]  = mkVec(1'b1, 1'b0, 32'h046, 3'b101, 32'h0,         32'hFFFF_CAFE, 4'd3);
        vecs[6]  = mkVec(1'b1, 1'b0, 32'h046, 3'b001, 32'h0,         32'h0000_CAFE, 4'd3);
        vecs[7]  = mkVec(1'b1, 1'b0, 32'h044, 3'b010, 32'h0,         32'hCAFE_1234, 4'd5);
        vecs[8]  = mkVec(1'b1, 1'b1, 32'h020, 3'b001, 32'h1234_BEEF, 32'h0,         4'd3);
        vecs[9]  = mkVec(1'b1, 1'b0, 32'h020, 3'b010, 32'h0,         32'h0000_BEEF, 4'd5);
        vecs[10] = mkVec(1'b1, 1'b0, 32'h021, 3'b000, 32'h0,         32'h0000_00BE, 4'd3);
        vecs[11] = mkVec(1'b1, 1'b1, 32'h030, 3'b000, 32'h5566_77AA, 32'h0,         4'd3);
        vecs[12] = mkVec(1'b1, 1'b0, 32'h030, 3'b010, 32'h0,         32'h0000_00AA, 4'd5);
        vecs[13] = mkVec(1'b0, 1'b0, 32'h10C, 3'b010, 32'h0,         32'hDEAD_C0DE, 4'd5);

        repeat (3) @(negedge clk);
        rst = 1'b1;

        $display("[TB] word fetch timing");
        if_addr  = 32'h100;
        if_valid = 1'b1;
        ifQ.push_back(32'h0000_0513);
        @(negedge clk);
        checkOutput("fetchMcValid", 135'(mc_valid), 135'(1));
        checkOutput("fetchMcAddr", 135'(mc_addr), 135'(32'h100));
        checkOutput("fetchMcType", 135'(mc_type), 135'(3'b010));
        checkOutput("fetchMcWr", 135'(mc_wr), 135'(0));
        waitReady(1'b0, "fetchTiming", cyc);
        if_valid = 1'b0;
        checkOutput("fetchReadyCycle", 135'(cyc), 135'(4));
        @(negedge clk);

        $display("[TB] transaction table");
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);
        checkOutput("storeByte0", 135'(mem[10'h020]), 135'(8'hEF));
        checkOutput("storeByte1", 135'(mem[10'h021]), 135'(8'hBE));
        checkOutput("storeByte2", 135'(mem[10'h022]), 135'(8'h00));

        $display("[TB] round-robin alternation");
        pulseReset();
        fork
            runFetches(3);
            runLoads(3);
        join
        @(negedge clk);
        checkOutput("altGrantCount", 135'(grantLog.size()), 135'(6));
        for (int i = 0; i < 6; i++) begin
            g = (i < grantLog.size()) ? grantLog[i] : 1'b0;
            checkOutput($sformatf("altGrant%0d", i), 135'(g), 135'((i % 2) == 0));
        end

        $display("[TB] flush during fetch");
        grantLog.delete();
        if_addr  = 32'h108;
        if_valid = 1'b1;
        @(negedge clk);
        checkOutput("clearMcValid", 135'(mc_valid), 135'(1));
        clear    = 1'b1;
        if_valid = 1'b0;
        ls_wr    = 1'b0;
        ls_addr  = 32'h048;
        ls_type  = 3'b010;
        ls_data  = 32'h0;
        ls_valid = 1'b1;
        lsQ.push_back(32'h4433_2211);
        @(negedge clk);
        clear = 1'b0;
        waitReady(1'b1, "clearLs", cyc);
        ls_valid = 1'b0;
        checkOutput("clearLsCycle", 135'(cyc), 135'(8));
        @(negedge clk);
        checkOutput("clearGrantCount", 135'(grantLog.size()), 135'(2));
        g = (grantLog.size() > 1) ? grantLog[1] : 1'b1;
        checkOutput("clearSecondGrantLs", 135'(g), 135'(0));

        $display("[TB] flush on the completion cycle");
        if_addr  = 32'h100;
        if_valid = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mc_ready === 1'b1) begin
                cyc = i;
                break;
            end
        end
        checkOutput("clearReadyCycle", 135'(cyc), 135'(4));
        clear    = 1'b1;
        if_valid = 1'b0;
        @(negedge clk);
        clear  = 1'b0;
        pulses = 0;
        repeat (4) begin
            if (if_ready === 1'b1) pulses++;
            @(negedge clk);
        end
        checkOutput("clearReadyNoPulse", 135'(pulses), 135'(0));

        $display("[TB] rdy stall during load");
        ls_wr    = 1'b0;
        ls_addr  = 32'h044;
        ls_type  = 3'b010;
        ls_valid = 1'b1;
        lsQ.push_back(32'hCAFE_1234);
        @(negedge clk);
        checkOutput("stallMcValid", 135'(mc_valid), 135'(1));
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stallMcAddr", 135'(mc_addr), 135'(32'h044));
        rdy = 1'b1;
        waitReady(1'b1, "stallLs", cyc);
        ls_valid = 1'b0;
        checkOutput("stallLsCycle", 135'(cyc), 135'(4));
        @(negedge clk);

        $display("[TB] reset during fetch");
        if_addr  = 32'h104;
        if_valid = 1'b1;
        @(negedge clk);
        checkOutput("rstMcValidBefore", 135'(mc_valid), 135'(1));
        rst      = 1'b0;
        if_valid = 1'b0;
        ifQ.delete();
        @(negedge clk);
        checkOutput("rstMcValidAfter", 135'(mc_valid), 135'(0));
        grantLog.delete();
        rst = 1'b1;
        fork
            runFetches(1);
            runLoads(1);
        join
        @(negedge clk);
        g = (grantLog.size() > 0) ? grantLog[0] : 1'b0;
        checkOutput("rstFetchWinsTie", 135'(g), 135'(1));
        checkOutput("rstQueuesDrained", 135'(ifQ.size() + lsQ.size()), 135'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter in front of `memory_controller`: accepts instruction-fetch word reads and load/store-buffer (LSB) accesses, grants one at a time, holds the controller request stable until `ready`, and returns the result to the winning requester. Round-robin fairness. A pipeline `clear` cancels fetch traffic without ever aborting a controller transaction already in flight.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low (state cleared on a `clk` edge while `rst`==0).
- `rdy` in 1: global enable; when 0, all state and registered outputs hold.
- `clear` in 1: pipeline flush; cancels fetch traffic.
- `if_valid` in 1: fetch request; held until `if_ready`.
- `if_addr` in 32: fetch word address.
- `if_ready` out 1: one-cycle response pulse.
- `if_data` out 32: fetched word; valid while `if_ready`.
- `ls_valid` in 1: LSB request; held until `ls_ready`.
- `ls_wr` in 1: 0 read, 1 write.
- `ls_addr` in 32: LSB byte address.
- `ls_type` in 3: controller size code: 000/001/010 byte/half/word zero-ext; 100/101 byte/half sign-ext.
- `ls_data` in 32: store data.
- `ls_ready` out 1: one-cycle response pulse.
- `ls_result` out 32: load result; valid while `ls_ready`.
- `mc_valid` out 1: request to controller.
- `mc_wr` out 1: write flag to controller.
- `mc_addr` out 32: address to controller.
- `mc_type` out 3: size code to controller.
- `mc_data` out 32: store data to controller.
- `mc_ready` in 1: controller done pulse.
- `mc_result` in 32: controller result; valid only while `mc_ready`.

## Operation
- States: IDLE, BUSY_IF, BUSY_LS, DRAIN, RESP.
- All outputs registered. Reset values: all 0; state IDLE; round-robin pointer `last_ls`=1 (fetch wins the first tie).
- IDLE, arbitration:
  - Fetch eligible iff `if_valid && !clear`.
  - Only fetch eligible: grant fetch.
  - Only `ls_valid`: grant LSB.
  - Both: grant fetch if `last_ls`, else LSB.
  - Grant sets `last_ls`, loads `mc_*`, sets `mc_valid`.
  - Fetch grant drives `mc_wr`=0, `mc_type`=010, `mc_addr`=`if_addr`, `mc_data`=0.
  - LSB grant copies `ls_*`.
  - Grant moves to BUSY_IF / BUSY_LS.
- BUSY_x:
  - `mc_*` held constant.
  - On `mc_ready`: `mc_valid`<=0, result latched into `if_data`/`ls_result`, matching ready <=1, state goes to RESP.
- RESP:
  - Ready pulse high for exactly this cycle.
  - Next edge: ready <=0, state goes to IDLE. No grant is made in RESP, so the requester's still-high valid is never re-granted.
- `clear` in BUSY_IF without `mc_ready`: go to DRAIN. `mc_valid` and `mc_*` stay asserted and stable until `mc_ready`. Then result discarded, `mc_valid`<=0, no `if_ready`, state goes to IDLE.
- `clear` in BUSY_IF on the same cycle as `mc_ready`: result discarded, no `if_ready`, state goes to IDLE.
- `clear` in RESP: the `if_ready` pulse is still issued; the fetch unit ignores it.
- `clear` never affects LSB transactions or `ls_ready`.
- IO writes stalled by the controller (`io_buffer_full`) simply extend BUSY_LS; no timeout.
- `rst`==0 mid-transaction: state goes to IDLE, all outputs 0, in-flight result lost. The controller is reset on the same edge.

## Timing
- Grant edge E0: `mc_valid`=1 from cycle E0+1; controller samples the request that cycle.
- `mc_ready` seen in cycle N: requester ready high in cycle N+1; earliest next grant is decided in cycle N+2; next `mc_valid` at N+3.
- `mc_valid` is low in the cycle after `mc_ready`, so the controller never restarts a finished request.
- Word fetch, controller 4-byte sequence: `mc_valid` at cycle 1, `mc_ready` at 4, `if_ready` at 5.
- Byte access: `mc_ready` the cycle after `mc_valid`; `ls_ready` one cycle later.
- `rdy`=0 freezes every register, including ready pulses and `mc_*`.

## Test plan
- Fetch word, `if_addr`=0x100, memory bytes 0x13,0x05,0x00,0x00 -> `mc_type`=010, `mc_addr`=0x100; `if_ready` one cycle with `if_data`=0x00000513; `mc_valid` low the cycle after `mc_ready`.
- `if_valid` and `ls_valid` both held high, 3 requests each -> grants alternate IF, LS, IF, LS, IF, LS starting with IF after reset; no request is served twice per ready pulse.
- LSB signed byte load, `ls_type`=100, byte 0x80 -> `ls_result`=0xFFFFFF80; LSB store half 0xBEEF at 0x20 -> bytes 0xEF@0x20, 0xBE@0x21 written; `ls_ready` pulses once.
- `clear` one cycle after a fetch grant -> `mc_valid` stays high until `mc_ready`, no `if_ready`; a pending LSB request is granted afterwards.
- `rdy`=0 for 3 cycles during BUSY_LS -> all outputs frozen; `rst`=0 during BUSY_IF -> next cycle all outputs 0, state IDLE, `last_ls`=1.
